// File: rtl/selector_frecuencia.sv
// Push-button front end for the frequency divider: synchronise, debounce, step on press,
// auto-repeat while held, and keep a saturating 8-bit selection code.
module selector_frecuencia #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 50000000,
    parameter int unsigned REPEAT_CYCLES   = 10000000,
    parameter int unsigned FREC_MIN        = 1,
    parameter int unsigned FREC_MAX        = 100,
    parameter int unsigned FREC_INIT       = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [7:0] frecnum,
    output logic       frec_changed,
    output logic       at_limit
);

    // Timer is at least 24 bits, widened when the hold/repeat periods need more.
    localparam int unsigned TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned TW   = ($clog2(TMAX) > 24) ? $clog2(TMAX) : 24;

    localparam logic [23:0]   DEB_LAST    = 24'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REP_LAST    = TW'(REPEAT_CYCLES - 1);
    localparam logic [7:0]    MIN8        = 8'(FREC_MIN);
    localparam logic [7:0]    MAX8        = 8'(FREC_MAX);
    localparam logic [7:0]    INIT8       = 8'(FREC_INIT);
    localparam logic          LIMIT_INIT  = (FREC_INIT == FREC_MIN) || (FREC_INIT == FREC_MAX);

    typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

    logic [1:0] raw, sync1, sync2, deb;
    logic       up_d, down_d;

    assign raw = {btn_down, btn_up};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_deb
        logic [23:0] cnt_q;
        logic        level_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q   <= '0;
                level_q <= 1'b0;
            end else if (sync2[i] == level_q) begin
                cnt_q   <= '0;
            end else if (cnt_q == DEB_LAST) begin
                level_q <= sync2[i];
                cnt_q   <= '0;
            end else begin
                cnt_q   <= cnt_q + 24'd1;
            end
        end

        assign deb[i] = level_q;
    end

    assign up_d   = deb[0];
    assign down_d = deb[1];

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          dir_q, dir_d;       // 1: stepping up
    logic          armed_q, armed_d;   // set only once both buttons have been low in idle
    logic          step, step_q, step_up_q;
    logic          release_seen;

    assign release_seen = dir_q ? (!up_d || down_d) : (!down_d || up_d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            dir_q     <= 1'b0;
            armed_q   <= 1'b0;
            step_q    <= 1'b0;
            step_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            dir_q     <= dir_d;
            armed_q   <= armed_d;
            step_q    <= step;
            step_up_q <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (armed_q && (up_d ^ down_d)) state_d = StHold;
            StHold:   if (release_seen) state_d = StIdle;
                      else if (timer_q == HOLD_LAST) state_d = StRepeat;
            StRepeat: if (release_seen) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        step    = 1'b0;
        timer_d = timer_q;
        dir_d   = dir_q;
        armed_d = armed_q;
        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                if (!up_d && !down_d) begin
                    armed_d = 1'b1;
                end else if (up_d && down_d) begin
                    armed_d = 1'b0;
                end else if (armed_q) begin
                    step    = 1'b1;
                    dir_d   = up_d;
                    armed_d = 1'b0;
                end
            end
            StHold, StRepeat: begin
                if (release_seen) begin
                    timer_d = '0;
                end else if (timer_q == ((state_q == StHold) ? HOLD_LAST : REP_LAST)) begin
                    step    = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: timer_d = '0;
        endcase
    end

    logic [8:0] up_sum, dn_diff;
    logic [7:0] frec_next;

    assign up_sum  = {1'b0, frecnum} + 9'd1;
    assign dn_diff = {1'b0, frecnum} - 9'd1;

    always_comb begin
        frec_next = frecnum;
        if (step_q) begin
            if (step_up_q) begin
                frec_next = (up_sum > {1'b0, MAX8}) ? MAX8 : up_sum[7:0];
            end else begin
                frec_next = (dn_diff[8] || (dn_diff < {1'b0, MIN8})) ? MIN8 : dn_diff[7:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frecnum      <= INIT8;
            frec_changed <= 1'b0;
            at_limit     <= LIMIT_INIT;
        end else begin
            frecnum      <= frec_next;
            frec_changed <= (frec_next != frecnum);
            at_limit     <= (frec_next == MIN8) || (frec_next == MAX8);
        end
    end

endmodule
